sdram_burst_scheduler: RTL and testbench

- Schedules SDRAM burst accesses between the write-side FIFO (camera → SDRAM) and the read-side FIFO (SDRAM → LCD).
- Decides which side gets the next burst and maintains the per-frame write and read address pointers, including wrap at the max address.
- Hands one burst command at a time to the SDRAM command controller and pulses the frame-done strobes used by bank switching.
- Sits in the clk_ref domain, between the dual-clock FIFOs and the SDRAM command/timing FSM.

---
 rtl/sdram_burst_scheduler_pkg.sv | 20 ++
 rtl/sdram_burst_scheduler_if.sv | 48 ++++
 rtl/sdram_burst_scheduler_addr_ptr.sv | 47 ++++
 rtl/sdram_burst_scheduler.sv | 118 +++++++++++
 tb/tb_sdram_burst_scheduler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_burst_scheduler_pkg.sv
// Shared encodings and default widths for the SDRAM burst scheduler slice.
package sdram_burst_scheduler_pkg;

    localparam int DEF_ADDR_W = 22;
    localparam int DEF_LEN_W  = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_RUN = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_RUN = 3'd4
    } state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

endpackage

// File: rtl/sdram_burst_scheduler_if.sv
// Burst scheduler bus: FIFO levels and frame geometry in, burst command and
// frame strobes out. The master modport is the scheduler's view.
interface sdram_burst_scheduler_if
    import sdram_burst_scheduler_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int LVL_W  = 10
);
    logic              sdram_init_done;
    logic [LVL_W-1:0]  wr_fifo_usedw;
    logic [LVL_W-1:0]  rd_fifo_usedw;
    logic              rd_enable;
    logic [LEN_W-1:0]  wr_length;
    logic [LEN_W-1:0]  rd_length;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_max_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_max_addr;
    logic              wr_load;
    logic              rd_load;
    logic              wr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] burst_addr;
    logic [LEN_W-1:0]  burst_len;
    logic              burst_ack;
    logic              burst_done;
    logic              frame_write_done;
    logic              frame_read_done;
    logic              busy;

    modport master (
        input  sdram_init_done, wr_fifo_usedw, rd_fifo_usedw, rd_enable,
               wr_length, rd_length, wr_addr, wr_max_addr, rd_addr, rd_max_addr,
               wr_load, rd_load, burst_ack, burst_done,
        output wr_req, rd_req, burst_addr, burst_len,
               frame_write_done, frame_read_done, busy
    );

    modport slave (
        output sdram_init_done, wr_fifo_usedw, rd_fifo_usedw, rd_enable,
               wr_length, rd_length, wr_addr, wr_max_addr, rd_addr, rd_max_addr,
               wr_load, rd_load, burst_ack, burst_done,
        input  wr_req, rd_req, burst_addr, burst_len,
               frame_write_done, frame_read_done, busy
    );

endinterface

// File: rtl/sdram_burst_scheduler_addr_ptr.sv
// Per-frame address pointer: advances by one burst, wraps to the frame start
// at max_addr with a one-cycle frame_done strobe; load forces the start address.
module sdram_addr_ptr
    import sdram_burst_scheduler_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] max_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] ptr,
    output logic              frame_done
);
    localparam int PW = ADDR_W + 1;

    // One extra bit so a burst ending exactly at the top of the address space still wraps.
    logic [PW-1:0] nxt;
    logic          wrap;

    assign nxt  = {1'b0, ptr} + PW'(len);
    assign wrap = nxt >= {1'b0, max_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load) begin
                ptr <= start_addr;
            end else if (step) begin
                if (wrap) begin
                    ptr        <= start_addr;
                    frame_done <= 1'b1;
                end else begin
                    ptr <= nxt[ADDR_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/sdram_burst_scheduler.sv
// Arbitrates SDRAM bursts between the camera write FIFO and the LCD read FIFO
// and issues one latched burst command at a time to the command FSM.
module sdram_burst_scheduler
    import sdram_burst_scheduler_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int LVL_W      = 10,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    sdram_burst_scheduler_if.master bus
);
    localparam int SW = ((LVL_W > LEN_W) ? LVL_W : LEN_W) + 2;

    state_t            state_q, state_d;
    grant_t            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_ok, rd_ok, rd_urgent;
    logic              gnt_wr, gnt_rd;

    // Read room test as used + len <= depth-1 so it cannot underflow.
    assign wr_ok     = (|bus.wr_length) &&
                       (SW'(bus.wr_fifo_usedw) >= SW'(bus.wr_length));
    assign rd_ok     = bus.rd_enable && (|bus.rd_length) &&
                       (SW'(bus.rd_fifo_usedw) + SW'(bus.rd_length) <= SW'(FIFO_DEPTH - 1));
    assign rd_urgent = rd_ok && (SW'(bus.rd_fifo_usedw) < SW'(bus.rd_length));

    always_comb begin
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (bus.sdram_init_done) begin
            if (rd_urgent)              gnt_rd = 1'b1;
            else if (wr_ok && rd_ok) begin
                if (last_q == GNT_RD)   gnt_wr = 1'b1;
                else                    gnt_rd = 1'b1;
            end
            else if (wr_ok)             gnt_wr = 1'b1;
            else if (rd_ok)             gnt_rd = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_rd) begin
                    state_d = ST_RD_REQ;
                    last_d  = GNT_RD;
                    addr_d  = rd_ptr;
                    len_d   = bus.rd_length;
                end else if (gnt_wr) begin
                    state_d = ST_WR_REQ;
                    last_d  = GNT_WR;
                    addr_d  = wr_ptr;
                    len_d   = bus.wr_length;
                end
            end
            ST_WR_REQ: if (bus.burst_ack)  state_d = ST_WR_RUN;
            ST_WR_RUN: if (bus.burst_done) state_d = ST_IDLE;
            ST_RD_REQ: if (bus.burst_ack)  state_d = ST_RD_RUN;
            ST_RD_RUN: if (bus.burst_done) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= GNT_RD;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    assign bus.wr_req     = (state_q == ST_WR_REQ);
    assign bus.rd_req     = (state_q == ST_RD_REQ);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.burst_addr = addr_q;
    assign bus.burst_len  = len_q;

    // len_q still holds the length of the burst that is finishing.
    sdram_addr_ptr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_ptr (
        .clk        (clk),
        .rst        (rst),
        .load       (bus.wr_load),
        .step       (bus.burst_done && (state_q == ST_WR_RUN)),
        .start_addr (bus.wr_addr),
        .max_addr   (bus.wr_max_addr),
        .len        (len_q),
        .ptr        (wr_ptr),
        .frame_done (bus.frame_write_done)
    );

    sdram_addr_ptr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_ptr (
        .clk        (clk),
        .rst        (rst),
        .load       (bus.rd_load),
        .step       (bus.burst_done && (state_q == ST_RD_RUN)),
        .start_addr (bus.rd_addr),
        .max_addr   (bus.rd_max_addr),
        .len        (len_q),
        .ptr        (rd_ptr),
        .frame_done (bus.frame_read_done)
    );

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed and randomized bench for sdram_burst_scheduler against a small
// arbitration/pointer model.
module tb_sdram_burst_scheduler;
    import sdram_burst_scheduler_pkg::*;

    localparam int FIFO_DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   m_wr_ptr, m_rd_ptr, m_last;  // m_last: 0 = WR, 1 = RD

    sdram_burst_scheduler_if bus ();
    sdram_burst_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected grant from current inputs: -1 none, 0 write, 1 read.
    function automatic int exp_side();
        int  wl, rl, wu, ru;
        bit  w, r;
        wl = int'(bus.wr_length);
        rl = int'(bus.rd_length);
        wu = int'(bus.wr_fifo_usedw);
        ru = int'(bus.rd_fifo_usedw);
        w  = (wl != 0) && (wu >= wl);
        r  = bus.rd_enable && (rl != 0) && (ru <= FIFO_DEPTH - 1 - rl);
        if (!bus.sdram_init_done) return -1;
        if (r && ru < rl)         return 1;
        if (w && r)               return (m_last == 1) ? 0 : 1;
        if (w)                    return 0;
        if (r)                    return 1;
        return -1;
    endfunction

    task automatic run_burst(input int side, input bit ld);
        int exp_addr, exp_len, start, maxa, nxt, n;
        bit exp_f;
        exp_addr = (side == 1) ? m_rd_ptr : m_wr_ptr;
        exp_len  = (side == 1) ? int'(bus.rd_length) : int'(bus.wr_length);
        start    = (side == 1) ? int'(bus.rd_addr) : int'(bus.wr_addr);
        maxa     = (side == 1) ? int'(bus.rd_max_addr) : int'(bus.wr_max_addr);
        n = 0;
        while (!(bus.wr_req || bus.rd_req) && n < 8) begin
            tick();
            n++;
        end
        chk("grant_seen", 32'(bus.wr_req | bus.rd_req), 32'd1);
        chk("wr_req", 32'(bus.wr_req), 32'(side == 0));
        chk("rd_req", 32'(bus.rd_req), 32'(side == 1));
        chk("burst_addr", 32'(bus.burst_addr), exp_addr);
        chk("burst_len", 32'(bus.burst_len), exp_len);
        chk("busy_req", 32'(bus.busy), 32'd1);
        chk("frame_quiet", 32'({bus.frame_write_done, bus.frame_read_done}), 32'd0);
        repeat ($urandom_range(0, 3)) tick();
        chk("req_hold", 32'((side == 1) ? bus.rd_req : bus.wr_req), 32'd1);
        bus.burst_ack = 1'b1;
        tick();
        bus.burst_ack = 1'b0;
        chk("req_drop", 32'(bus.wr_req | bus.rd_req), 32'd0);
        chk("busy_run", 32'(bus.busy), 32'd1);
        repeat ($urandom_range(0, 3)) tick();
        bus.burst_done = 1'b1;
        if (ld) begin
            if (side == 1) bus.rd_load = 1'b1;
            else           bus.wr_load = 1'b1;
        end
        tick();
        bus.burst_done = 1'b0;
        bus.wr_load    = 1'b0;
        bus.rd_load    = 1'b0;
        nxt   = exp_addr + exp_len;
        exp_f = 1'b0;
        if (ld)               nxt = start;
        else if (nxt >= maxa) begin nxt = start; exp_f = 1'b1; end
        if (side == 1) m_rd_ptr = nxt;
        else           m_wr_ptr = nxt;
        m_last = side;
        chk("frame_write_done", 32'(bus.frame_write_done), 32'(side == 0 && exp_f));
        chk("frame_read_done", 32'(bus.frame_read_done), 32'(side == 1 && exp_f));
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic pick_geom(output int start, output int len, output int maxa);
        case ($urandom_range(0, 3))
            0:       len = 64;
            1:       len = 128;
            2:       len = 256;
            default: len = 0;
        endcase
        start = int'($urandom_range(0, 4000)) * 1024;
        maxa  = start + ((len == 0) ? 256 : len) * int'($urandom_range(1, 3));
    endtask

    initial begin
        int n, side, s, l, m;
        rst = 1'b1;
        bus.sdram_init_done = 1'b0;
        bus.wr_fifo_usedw = '0;
        bus.rd_fifo_usedw = '0;
        bus.rd_enable     = 1'b0;
        bus.wr_length     = 9'd256;
        bus.rd_length     = 9'd256;
        bus.wr_addr       = '0;
        bus.wr_max_addr   = 22'd768;
        bus.rd_addr       = '0;
        bus.rd_max_addr   = 22'd1024;
        bus.wr_load       = 1'b0;
        bus.rd_load       = 1'b0;
        bus.burst_ack     = 1'b0;
        bus.burst_done    = 1'b0;
        m_wr_ptr = 0;
        m_rd_ptr = 0;
        m_last   = 1;
        repeat (2) tick();
        chk("rst_outputs", 32'({bus.wr_req, bus.rd_req, bus.busy,
                                bus.frame_write_done, bus.frame_read_done}), 32'd0);
        chk("rst_burst_addr", 32'(bus.burst_addr), 32'd0);
        chk("rst_burst_len", 32'(bus.burst_len), 32'd0);
        rst = 1'b0;

        // Init gating, then first write burst.
        bus.wr_fifo_usedw = 10'd300;
        repeat (4) tick();
        chk("no_req_before_init", 32'(bus.wr_req | bus.rd_req), 32'd0);
        bus.sdram_init_done = 1'b1;
        tick();
        tick();
        chk("init_wr_req", 32'(bus.wr_req), 32'd1);
        run_burst(0, 1'b0);

        // Contended alternation; the write frame wraps on its third burst.
        bus.rd_enable     = 1'b1;
        bus.rd_fifo_usedw = 10'd600;
        run_burst(1, 1'b0);
        run_burst(0, 1'b0);
        run_burst(1, 1'b0);
        run_burst(0, 1'b0);

        // Read-only burst leaves last_grant=RD; urgent read still wins next.
        bus.wr_fifo_usedw = 10'd0;
        run_burst(1, 1'b0);
        bus.wr_fifo_usedw = 10'd300;
        bus.rd_fifo_usedw = 10'd100;
        run_burst(1, 1'b0);

        // Load coinciding with burst_done at 512: pointer to 0, no frame strobe.
        bus.rd_enable = 1'b0;
        run_burst(0, 1'b0);
        run_burst(0, 1'b0);
        run_burst(0, 1'b1);
        run_burst(0, 1'b0);

        // Stray ack/done while idle are ignored.
        bus.sdram_init_done = 1'b0;
        bus.burst_ack = 1'b1;
        tick();
        bus.burst_ack  = 1'b0;
        bus.burst_done = 1'b1;
        tick();
        bus.burst_done = 1'b0;
        chk("stray_busy", 32'(bus.busy), 32'd0);
        chk("stray_frame", 32'({bus.frame_write_done, bus.frame_read_done}), 32'd0);
        bus.sdram_init_done = 1'b1;
        run_burst(0, 1'b0);

        // Asynchronous reset while a read request is pending.
        bus.wr_fifo_usedw = 10'd0;
        bus.rd_enable     = 1'b1;
        bus.rd_fifo_usedw = 10'd600;
        n = 0;
        while (!bus.rd_req && n < 8) begin
            tick();
            n++;
        end
        chk("rd_req_pending", 32'(bus.rd_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_rd_req", 32'(bus.rd_req), 32'd0);
        chk("rst_async_busy", 32'(bus.busy), 32'd0);
        bus.rd_enable = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_rd_ptr", 32'(dut.u_rd_ptr.ptr), 32'd0);
        m_wr_ptr = 0;
        m_rd_ptr = 0;
        m_last   = 1;

        // Randomized traffic with periodic frame reconfiguration.
        for (int it = 0; it < 80; it++) begin
            if (it % 10 == 0) begin
                bus.sdram_init_done = 1'b0;
                pick_geom(s, l, m);
                bus.wr_addr = 22'(s); bus.wr_length = 9'(l); bus.wr_max_addr = 22'(m);
                m_wr_ptr = s;
                pick_geom(s, l, m);
                bus.rd_addr = 22'(s); bus.rd_length = 9'(l); bus.rd_max_addr = 22'(m);
                m_rd_ptr = s;
                bus.wr_load = 1'b1;
                bus.rd_load = 1'b1;
                tick();
                bus.wr_load = 1'b0;
                bus.rd_load = 1'b0;
                bus.sdram_init_done = 1'b1;
            end
            bus.wr_fifo_usedw = 10'($urandom_range(0, 1023));
            bus.rd_fifo_usedw = 10'($urandom_range(0, 1023));
            bus.rd_enable     = 1'($urandom_range(0, 1));
            side = exp_side();
            if (side < 0) begin
                repeat (4) tick();
                chk("no_grant", 32'(bus.wr_req | bus.rd_req), 32'd0);
            end else begin
                run_burst(side, $urandom_range(0, 7) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
